thirty_two_bit_divider: RTL
===========================

Name: thirty_two_bit_divider

Overview:
- Iterative 32-bit integer divider. It is the inverse-operation companion to the sequential multiplier in the execute stage's M-extension unit.
- Computes the RISC-V DIV/DIVU/REM/REMU results using a radix-2 restoring shift-subtract loop.
- Uses a start/done handshake. One division is in flight at a time.
- Results are RISC-V-compliant for divide-by-zero and signed overflow.

Parameters:
- WIDTH, 32, operand and result width in bits. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- signed_op  input  1  1 = DIV/REM semantics (two's complement); 0 = DIVU/REMU.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle pulse; results are valid from this cycle on.
- quotient  output  WIDTH  quotient, rounded toward zero.
- remainder  output  WIDTH  remainder; its sign follows the dividend.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0.
  - All internal registers cleared.
  - Applies immediately, including mid-operation. The aborted operation produces no done.
- States: IDLE, CALC, FIX.
  - IDLE: at an edge with start=1:
    - Capture abs(dividend) and abs(divisor) when signed_op=1, else the raw values.
    - Record the quotient sign (dividend[31]^divisor[31]) and the remainder sign (dividend[31]), gated by signed_op.
    - Clear the partial remainder; iteration counter=0; busy<=1.
  - Special cases are detected in IDLE from the raw inputs and go straight to FIX with preloaded results:
    - divisor==0: quotient=all ones, remainder=dividend (unmodified).
    - signed_op=1, dividend=0x80000000, divisor=0xFFFFFFFF: quotient=0x80000000, remainder=0.
  - Otherwise go to CALC.
  - CALC, one bit per edge, for WIDTH edges:
    - Shift {partial_rem, quotient_reg} left by 1.
    - Trial subtract divisor from partial_rem, using WIDTH+1 bits for the borrow.
    - If non-negative: keep the difference and set quotient LSB=1. Else restore and set LSB=0.
    - The counter wraps from WIDTH-1 to FIX; it must not roll over into a 33rd iteration.
  - FIX, one edge:
    - Negate the quotient if its sign flag is set; negate the remainder if its sign flag is set. Special-case results pass through unchanged.
    - Register quotient/remainder, done<=1, busy<=0, go to IDLE.
- Latency, start accepted at edge k:
  - Normal operation: done high in the cycle after edge k+WIDTH+1 (33 edges for WIDTH=32).
  - Special case: done high in the cycle after edge k+1.
- done is high for exactly one cycle.
- quotient and remainder hold their value until the next done. They do not change during CALC.
- start while busy=1 is ignored: no queueing, no operand update.
- start in the same cycle that done is high (busy already 0) is accepted; back-to-back throughput is 1 op per WIDTH+2 cycles.
- A dividend or divisor change while busy=1 has no effect.
- Remainder magnitude is always less than the divisor magnitude.
- Signed results satisfy dividend = quotient*divisor + remainder, modulo 2^WIDTH.
- No X may propagate from the outputs after reset.

Test Plan:
1. Unsigned 100/7 (signed_op=0) -> done 33 cycles after start; quotient=14, remainder=2; busy high for exactly 33 cycles.
2. Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
3. Divide by zero, both modes: 5/0 -> quotient=0xFFFFFFFF, remainder=5, done 1 cycle after start. Signed -5/0 -> remainder=0xFFFFFFFB.
4. Signed overflow 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. The same operands unsigned -> quotient=0, remainder=0x80000000 after 33 cycles.
5. Handshake stress:
   - start pulsed with 0x12345678/0x10 while busy -> ignored; the first op's result (e.g. 1000/10 -> 100, 0) is intact.
   - start asserted on the done cycle with 0xFFFFFFFF/0xFFFFFFFF unsigned -> accepted; quotient=1, remainder=0.
6. Reset mid-operation: rst_n low at iteration 15 -> busy, done, quotient and remainder go to 0 immediately with no done pulse. After release, 81/9 -> quotient=9, remainder=0.

Source files
------------

// File: rtl/thirty_two_bit_divider.sv
// Iterative radix-2 restoring divider producing RISC-V DIV/DIVU/REM/REMU results.
// One bit per clock; special cases (divide-by-zero, signed overflow) bypass the loop.
module thirty_two_bit_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    // state | meaning
    // IDLE  | waiting for start; special cases detected here
    // CALC  | one shift-subtract iteration per edge, WIDTH edges
    // FIX   | sign correction, results registered, done pulse

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             special_q, special_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic             is_zero, is_ovf;
    logic [WIDTH:0]   rem_shift, trial;

    assign dvd_neg   = signed_op & dividend[WIDTH-1];
    assign dvs_neg   = signed_op & divisor[WIDTH-1];
    assign dvd_abs   = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dvs_abs   = dvs_neg ? (~divisor + 1'b1) : divisor;
    assign is_zero   = (divisor == '0);
    assign is_ovf    = signed_op && (dividend == MIN_NEG) && (divisor == '1);

    // The partial remainder is always below the divisor, so one extra bit
    // is enough to hold the borrow of the trial subtraction.
    assign rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, div_q};

    always_comb begin
        state_d     = state_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        special_d   = special_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    qneg_d = dvd_neg ^ dvs_neg;
                    rneg_d = dvd_neg;
                    div_d  = dvs_abs;
                    if (is_zero) begin
                        quot_d    = '1;
                        rem_d     = dividend;
                        special_d = 1'b1;
                        state_d   = FIX;
                    end else if (is_ovf) begin
                        quot_d    = MIN_NEG;
                        rem_d     = '0;
                        special_d = 1'b1;
                        state_d   = FIX;
                    end else begin
                        quot_d    = dvd_abs;
                        rem_d     = '0;
                        special_d = 1'b0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d  = trial[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIX: begin
                quotient_d  = (qneg_q && !special_q) ? (~quot_q + 1'b1) : quot_q;
                remainder_d = (rneg_q && !special_q) ? (~rem_q + 1'b1) : rem_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            quot_q      <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            special_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            special_q   <= special_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule
